// File: rtl/conv55_pkg.sv
// conv55_pkg: shared widths and FSM state type for the 5x5 6-bit convolution controller
package conv55_pkg;
  localparam int TAPS   = 25;
  localparam int DATA_W = 6;
  localparam int SUM_W  = 18;
  localparam int WIN_W  = TAPS * DATA_W;
  localparam int IDX_W  = $clog2(TAPS);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;
endpackage

// File: rtl/conv55_res_fifo.sv
// conv55_res_fifo: show-ahead result FIFO with occupancy count; push/pop are ignored when full/empty
module conv55_res_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign do_push = push_i && cnt_q != (AW+1)'(DEPTH);
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/conv55_6bit_ctrl.sv
// conv55_6bit_ctrl: kernel load, window issue and latency-tracked result buffering for the 5x5 conv datapath.
// Defining CONV55_CTRL_PERF_EN adds the perf_stall_cnt window-stall counter.
module conv55_6bit_ctrl
  import conv55_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [15:0]       cfg_frame_len,
  input  logic              k_valid,
  output logic              k_ready,
  input  logic [DATA_W-1:0] k_data,
  input  logic              win_valid,
  output logic              win_ready,
  input  logic [WIN_W-1:0]  win_data,
  output logic [WIN_W-1:0]  dp_in_data,
  output logic [WIN_W-1:0]  dp_kernel,
  input  logic [SUM_W-1:0]  dp_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef CONV55_CTRL_PERF_EN
  ,output logic [31:0]      perf_stall_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e           state_q, state_d;
  logic [15:0]      remaining_q, remaining_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIN_W-1:0] kern_q, in_q;
  logic             issue_q, cap_q;
  logic [1:0]       inflight;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_empty, k_fire, win_fire, last_res;
  assign inflight   = {1'b0, issue_q} + {1'b0, cap_q};
  assign k_fire     = k_valid && k_ready;
  assign win_fire   = win_valid && win_ready;
  // Every window is accepted before its result is captured, so the capture with nothing behind it is the last.
  assign last_res   = cap_q && !issue_q && remaining_q == '0;
  assign dp_in_data = in_q;
  assign dp_kernel  = kern_q;
  assign busy       = state_q != IDLE;
  assign out_valid  = !fifo_empty;
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    k_ready     = 1'b0;
    win_ready   = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: if (cfg_start) begin
        state_d     = LOAD;
        remaining_d = cfg_frame_len;
        idx_d       = '0;
      end
      LOAD: begin
        k_ready = 1'b1;
        if (k_valid) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(TAPS - 1)) state_d = remaining_q == '0 ? DRAIN : RUN;
        end
      end
      RUN: begin
        // Reserve a FIFO slot for every result still in the datapath so backpressure never drops one.
        win_ready = remaining_q != '0 && fifo_cnt + CW'(inflight) < CW'(FIFO_DEPTH);
        if (win_valid && win_ready) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = DRAIN;
        end
      end
      default: if (inflight == 2'd0 && fifo_empty) begin
        state_d = IDLE;
        done    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      idx_q       <= '0;
      kern_q      <= '0;
      in_q        <= '0;
      issue_q     <= 1'b0;
      cap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      if (k_fire) kern_q[32'(idx_q)*DATA_W +: DATA_W] <= k_data;
      if (win_fire) in_q <= win_data;
      issue_q <= win_fire;
      cap_q   <= issue_q;
    end
  end
  conv55_res_fifo #(
    .W    (SUM_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (cap_q),
    .din_i  ({last_res, dp_sum}),
    .pop_i  (out_ready),
    .dout_o ({out_last, out_data}),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );
`ifdef CONV55_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_stall_cnt <= '0;
    else if (state_q == IDLE && cfg_start) perf_stall_cnt <= '0;
    else if (state_q == RUN && win_valid && !win_ready && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: doc/conv55_6bit_ctrl.md
# conv55_6bit_ctrl

Sequencing controller for the 5x5, 6-bit DSP convolution datapath: it loads the 25 kernel taps serially, accepts pre-formed 25-pixel windows over a valid/ready stream, and drives the datapath. It tracks the datapath's fixed one-register latency and buffers results in a small FIFO so downstream backpressure never stalls the free-running datapath. It sits between the line-buffer/window generator and the result writer; the datapath is instantiated beside it at top level.

## Interface
- TAPS, 25, kernel taps and window pixels per operation
- DATA_W, 6, pixel/tap width (unsigned)
- SUM_W, 18, datapath result width
- FIFO_DEPTH, 4, result FIFO entries (power of two, ≥4)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  start a job; sampled only in IDLE
- cfg_frame_len  in  16  windows in the job, captured on cfg_start
- k_valid / k_ready  in/out  1  kernel tap handshake
- k_data  in  DATA_W  kernel tap, tap 0 first
- win_valid / win_ready  in/out  1  window handshake
- win_data  in  TAPS*DATA_W  window, pixel i at bits [6i+5:6i]
- dp_in_data  out  TAPS*DATA_W  to datapath pixel inputs (registered)
- dp_kernel  out  TAPS*DATA_W  to datapath kernel inputs (tap registers)
- dp_sum  in  SUM_W  registered datapath result
- out_valid / out_ready  out/in  1  result handshake
- out_data  out  SUM_W  result
- out_last  out  1  marks final result of the job
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at job end

## Operation
- States: IDLE → LOAD → RUN → DRAIN → IDLE.
- IDLE: cfg_start=1 captures cfg_frame_len; next state LOAD. cfg_start is ignored in all other states.
- LOAD: k_ready=1. Each k handshake writes tap[idx], idx 0..24. Acceptance of tap 24 → RUN (or DRAIN if frame_len=0).
- RUN: win_ready = (remaining>0) && (fifo_count + inflight < FIFO_DEPTH). Each handshake registers win_data into dp_in_data, decrements remaining, and sets issue-valid. When remaining reaches 0 → DRAIN.
- Pipeline: the issue-valid flag becomes capture-valid one cycle later. In that cycle, dp_sum is written to the FIFO with last = (this is result #frame_len). inflight counts issue-valid plus capture-valid (0..2).
- DRAIN: wait until inflight=0 and the FIFO is empty, then → IDLE with done=1 for that cycle. For frame_len=0, done fires on the cycle after LOAD ends, and no output is produced.
- FIFO: show-ahead. out_valid=!empty. A pop on out_valid&&out_ready. A simultaneous push and pop is legal; count is unchanged.
- Tap registers persist across jobs and are reloaded each LOAD. dp_kernel is driven from them continuously.
- Arithmetic is unsigned. Maximum sum 25·63·63=99225 fits SUM_W; no saturation.
- Reset (async, any time): state IDLE, taps 0, dp_in_data 0, FIFO empty, counters 0. All outputs 0: k_ready, win_ready, out_valid, out_data, out_last, busy, done, dp_*. A job in flight is discarded.

## Timing
- Window handshake in cycle t: dp_in_data valid t+1. dp_sum valid t+2, pushed at the end of t+2. out_valid earliest t+3. Latency 3 cycles.
- Sustained throughput is 1 window/cycle with out_ready held high.
- With out_ready low, at most FIFO_DEPTH results are held; win_ready drops so that no result is ever lost.
- No combinational path from out_ready to win_ready or k_ready.

## Configuration
- CONV55_CTRL_PERF_EN defined: adds output perf_stall_cnt[31:0]. It counts RUN cycles with win_valid=1 && win_ready=0, clears on an accepted cfg_start, and saturates at 2^32−1.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Package conv55_pkg: TAPS, DATA_W, SUM_W, the state enum (IDLE/LOAD/RUN/DRAIN), and a window-width localparam.
- One sub-module, conv55_res_fifo: show-ahead FIFO of {last, SUM_W} with count output. The controller FSM, tap registers and latency tracking stay in the top module.

## Test plan
- Taps all 1, frame_len=3, windows all 63, out_ready=1 → out_data=1575 ×3. out_last on the 3rd; done one cycle after the 3rd pop. First out_valid 3 cycles after the first window handshake.
- tap i=i, window all 2 → out_data=600. Tap i=i, window pixel i=1 only at i=24 → 24.
- frame_len=8, out_ready low for 10 cycles after start → exactly 4 windows accepted. win_ready stays low until a pop. All 8 results arrive in order with none lost.
- frame_len=0 → 25 taps accepted, win_ready never high, no out_valid, done pulses once.
- rst_n low mid-RUN with 2 results buffered → all outputs 0 immediately. After release, a new job starts from LOAD with correct results.
- cfg_start pulsed during RUN → ignored; the job completes with its original frame_len. With the macro defined, window stalls from the blocked FIFO increment perf_stall_cnt by the stalled-cycle count.
